// File: rtl/ddr3_i2c_byte_master.sv
// Avalon-MM byte-level I2C master: one command = optional START, one byte, ACK slot, optional STOP.
// Define DDR3_I2C_CLK_STRETCH_EN to honour slave clock stretching on SCL.
//
// state   | meaning
// IDLE    | waiting for a command; SCL held low if the last command had no STOP
// START   | SDA/SCL released 2 quarters, then SDA low 2 quarters
// DATA    | 8 bits MSB first, 4 quarters each
// ACK     | ninth bit: slave ACK on write, master ACK/NACK on read
// STOP    | SDA low/SCL low, SCL released, then SDA released
module ddr3_i2c_byte_master #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        sda_in,
    input  logic        scl_in,
    output logic        sda_oe,
    output logic        scl_oe
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_ACK, S_STOP} state_t;

    state_t      state, state_nx;
    logic [1:0]  qtr, qtr_nx;
    logic [2:0]  bit_cnt, bit_cnt_nx;
    logic [15:0] div_cnt;
    logic [7:0]  tx_sh, rx_sh, rx_byte;
    logic        cmd_stop, cmd_read, cmd_ack;
    logic        nack_rx, cmd_lost, bus_held;
    logic        sda_meta, sda_s, scl_meta, scl_s;
    logic        busy, wr_cmd, rd_status, accept, stall, tick, last_qtr;
    logic        unused;

    assign busy      = (state != S_IDLE);
    assign wr_cmd    = chipselect && !write_n && (address == 2'd0);
    assign rd_status = chipselect && write_n && (address == 2'd1);
    assign accept    = wr_cmd && !busy;

`ifdef DDR3_I2C_CLK_STRETCH_EN
    // The first two cycles of Q2 are masked: scl_s still shows our own pull-down through the synchroniser.
    assign stall = busy && qtr[1] && !scl_s && !((qtr == 2'd2) && (div_cnt < 16'd2));
`else
    assign stall = 1'b0;
`endif

    assign tick     = busy && !stall && (div_cnt == 16'(CLK_DIV - 1));
    assign last_qtr = tick && (qtr == 2'd3);
    assign unused   = ^{writedata[31:12], scl_s};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            qtr     <= 2'd0;
            bit_cnt <= 3'd0;
        end else begin
            state   <= state_nx;
            qtr     <= qtr_nx;
            bit_cnt <= bit_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        qtr_nx     = qtr;
        bit_cnt_nx = bit_cnt;
        sda_oe     = 1'b0;
        scl_oe     = 1'b0;
        if (busy && tick)
            qtr_nx = qtr + 2'd1;
        case (state)
            S_IDLE: begin
                scl_oe = bus_held;
                if (accept) begin
                    qtr_nx     = 2'd0;
                    bit_cnt_nx = 3'd0;
                    state_nx   = writedata[8] ? S_START : S_DATA;
                end
            end
            S_START: begin
                sda_oe = qtr[1];
                if (last_qtr)
                    state_nx = S_DATA;
            end
            S_DATA: begin
                scl_oe = !qtr[1];
                sda_oe = !cmd_read && !tx_sh[7];
                if (last_qtr) begin
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_nx = S_ACK;
                end
            end
            S_ACK: begin
                scl_oe = !qtr[1];
                sda_oe = cmd_read && !cmd_ack;
                if (last_qtr)
                    state_nx = cmd_stop ? S_STOP : S_IDLE;
            end
            S_STOP: begin
                scl_oe = (qtr == 2'd0);
                sda_oe = !qtr[1];
                if (last_qtr)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sda_meta <= 1'b1;
            sda_s    <= 1'b1;
            scl_meta <= 1'b1;
            scl_s    <= 1'b1;
            div_cnt  <= 16'd0;
            tx_sh    <= 8'd0;
            rx_sh    <= 8'd0;
            rx_byte  <= 8'd0;
            cmd_stop <= 1'b0;
            cmd_read <= 1'b0;
            cmd_ack  <= 1'b0;
            nack_rx  <= 1'b0;
            cmd_lost <= 1'b0;
            bus_held <= 1'b0;
            readdata <= 32'd0;
        end else begin
            sda_meta <= sda_in;
            sda_s    <= sda_meta;
            scl_meta <= scl_in;
            scl_s    <= scl_meta;

            if (accept) begin
                div_cnt  <= 16'd0;
                tx_sh    <= writedata[7:0];
                cmd_stop <= writedata[9];
                cmd_read <= writedata[10];
                cmd_ack  <= writedata[11];
            end else if (busy && !stall) begin
                div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
            end

            if (state == S_DATA && last_qtr) begin
                tx_sh <= {tx_sh[6:0], 1'b0};
                rx_sh <= {rx_sh[6:0], sda_s};
            end

            if (state == S_ACK && last_qtr) begin
                if (cmd_read)
                    rx_byte <= rx_sh;
                else
                    nack_rx <= sda_s;
                bus_held <= !cmd_stop;
            end

            // A loss in the same cycle as a status read must survive the clear.
            if (wr_cmd && busy)
                cmd_lost <= 1'b1;
            else if (rd_status)
                cmd_lost <= 1'b0;

            if (chipselect && write_n) begin
                case (address)
                    2'd1:    readdata <= {29'd0, cmd_lost, nack_rx, busy};
                    2'd2:    readdata <= {24'd0, rx_byte};
                    default: readdata <= 32'd0;
                endcase
            end
        end
    end

endmodule

// File: doc/ddr3_i2c_byte_master.md
DDR3_I2C_BYTE_MASTER -- requirements
Module: ddr3_i2c_byte_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, giving clk cycles per SCL quarter-period (SCL = clk/(4*CLK_DIV)); legal range 2..65535.
REQ-002 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port address  in  2  Avalon-MM word address.
REQ-005 SHALL have port chipselect  in  1  slave select.
REQ-006 SHALL have port write_n  in  1  active-low write strobe.
REQ-007 SHALL have port writedata  in  32  write data.
REQ-008 SHALL have port readdata  out  32  registered read data, 1-cycle latency.
REQ-009 SHALL have port sda_in  in  1  SDA pin level.
REQ-010 SHALL have port scl_in  in  1  SCL pin level.
REQ-011 SHALL have port sda_oe  out  1  1 = pull SDA low; 0 = release (open-drain).
REQ-012 SHALL have port scl_oe  out  1  1 = pull SCL low; 0 = release.

Function
REQ-013 SHALL resynchronise sda_in and scl_in through 2 flip-flops before use.
REQ-014 SHALL decode a write (chipselect & ~write_n) to address 0 as a command: [7:0] tx byte, [8] START, [9] STOP, [10] READ, [11] master ACK level on read (0 = ACK, 1 = NACK).
REQ-015 SHALL return on address 1 read: [0] busy, [1] nack_rx (slave NACK on last write byte), [2] cmd_lost; upper bits 0.
REQ-016 SHALL return on address 2 read: [7:0] last received byte; upper bits 0; address 3 reads 0.
REQ-017 SHALL accept a command only when busy = 0; busy SHALL assert on the clock edge after the accepting write.
REQ-018 SHALL ignore a command written while busy and set sticky cmd_lost; reading address 1 SHALL clear cmd_lost one cycle after the read unless a new loss coincides (set wins).
REQ-019 SHALL advance phases on a divider tick every CLK_DIV clk cycles; the divider SHALL restart at 0 on command acceptance.
REQ-020 SHALL implement states IDLE -> START (if bit 8) -> DATA (8 bits, MSB first) -> ACK -> STOP (if bit 9) -> IDLE; START/STOP skipped when their bits are 0.
REQ-021 SHALL, per bit (4 quarters): Q0 SCL low, set SDA; Q1 SCL low; Q2 SCL released; Q3 SCL released, sample SDA at end of Q3.
REQ-022 SHALL generate START as SDA released/SCL released for 2 quarters, then SDA low for 2 quarters; STOP as SDA low/SCL low, SCL released, then SDA released for 2 quarters.
REQ-023 SHALL, on write byte, release SDA during ACK and latch nack_rx = sampled SDA; on READ, release SDA for data bits, shift in samples and drive bit 11 during ACK.
REQ-024 SHALL update the address-2 byte only on completion of a READ command.
REQ-025 SHALL hold SCL low (scl_oe = 1) while IDLE after a command without STOP, preserving bus ownership; released after STOP.
REQ-026 SHALL deassert busy in the cycle after the final quarter of the last phase.

Reset
REQ-027 SHALL on reset, at any time including mid-transfer, force state IDLE, sda_oe = 0, scl_oe = 0, readdata = 0, busy = 0, nack_rx = 0, cmd_lost = 0, rx byte = 0, divider = 0.

Configuration
REQ-028 SHALL, with macro DDR3_I2C_CLK_STRETCH_EN defined, freeze the divider in Q2/Q3 while synchronised scl_in = 0 after SCL release (slave clock stretching), resuming the next cycle scl_in = 1.
REQ-029 SHALL, without DDR3_I2C_CLK_STRETCH_EN, ignore scl_in entirely; timing purely from divider.

Verification
REQ-030 SHALL cover: CLK_DIV=4, write 0x3A0 (START|STOP, byte 0xA0), slave ACKs -> busy for 4+36+4 quarters x 4 clk = 176 cycles, SDA bits 1010_0000, nack_rx=0.
REQ-031 SHALL cover: write 0x0A0, no slave (SDA pulled high) -> nack_rx=1, SCL left low, busy clears.
REQ-032 SHALL cover: write 0xE00 (READ|STOP|NACK), slave drives 0x5C -> address 2 reads 0x5C, SDA released in ACK, STOP issued.
REQ-033 SHALL cover: second write to address 0 while busy -> command ignored, status reads 0x5 then 0x1.
REQ-034 SHALL cover: reset asserted during bit 3 -> sda_oe=scl_oe=0 asynchronously, status 0 after reset release.
REQ-035 SHALL cover (DDR3_I2C_CLK_STRETCH_EN): slave holds SCL low 20 cycles on bit 0 -> transfer extended exactly 20 cycles; without the macro, length unchanged.
